// File: rtl/dbus_mmio_pkg.sv
// Shared definitions for the dbus_mmio peripheral: register word offsets
// (daddr[3:2]), STATUS bit positions, reset constants and a byte-enable
// merge helper used by the writable registers.
package dbus_mmio_pkg;

    // Word offsets within the 16-byte window, compared against daddr[3:2]
    localparam logic [1:0] OFF_TIMER  = 2'd0;
    localparam logic [1:0] OFF_CMP    = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_TXDATA = 2'd3;

    // STATUS bit positions
    localparam int ST_PENDING   = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_MSB = 7;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    // Replace the bytes of old_v selected by be with the matching bytes of new_v
    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dbus_mmio_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   push_i, data_i   write request and data
//   pop_i            read request (ignored while empty)
//   data_o           head entry, forced to 0 while empty
//   full_o, empty_o  registered occupancy flags
//   count_o          number of stored entries
//   rej_o            push refused this cycle (full with no pop)
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic             rej_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the head is leaving.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rej_o   = push_i && !push_ok;

    // Gate the head so the output is never driven from uninitialised storage
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/dbus_mmio.sv
// dbus_mmio: memory-mapped slave on the core data port. Owns a free-running
// 32-bit timer with a compare interrupt and a byte-wide transmit FIFO drained
// over a valid/ready stream. Reads are combinational (zero latency).
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   daddr_i, dwdata_i       CPU data address / write data
//   dwe_i                   CPU byte write enables
//   rdata_o, hit_o          read data (0 when not hit), window decode
//   irq_o                   compare-match pending flag
//   tx_data_o, tx_valid_o   FIFO head byte and not-empty
//   tx_ready_i              consumer accepts the head
module dbus_mmio
    import dbus_mmio_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [3:0]  dwe_i,
    output logic [31:0] rdata_o,
    output logic        hit_o,
    output logic        irq_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        pending_q, pending_d;
    logic        overflow_q, overflow_d;

    logic [1:0]  off;
    logic        wr, wr_timer, wr_cmp, wr_status, push, pop, match;
    logic        fifo_full, fifo_empty, fifo_rej;
    logic [CW-1:0] fifo_count;
    logic [31:0] status;

    // Byte-offset bits of the address do not select anything
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^daddr_i[1:0];

    assign hit_o     = (daddr_i[31:4] == BASE[31:4]);
    assign off       = daddr_i[3:2];
    assign wr        = hit_o && (dwe_i != 4'b0000);
    assign wr_timer  = wr && (off == OFF_TIMER);
    assign wr_cmp    = wr && (off == OFF_CMP);
    // W1C bits live in byte 0
    assign wr_status = wr && (off == OFF_STATUS) && dwe_i[0];
    assign push      = wr && (off == OFF_TXDATA) && dwe_i[0];
    assign pop       = tx_valid_o && tx_ready_i;
    assign match     = (timer_q == cmp_q);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (dwdata_i[7:0]),
        .pop_i   (pop),
        .data_o  (tx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .rej_o   (fifo_rej)
    );

    assign tx_valid_o = !fifo_empty;
    assign irq_o      = pending_q;

    always_comb begin
        // A write replaces enabled bytes and suppresses that cycle's increment
        timer_d = wr_timer ? apply_be(timer_q, dwdata_i, dwe_i) : timer_q + 32'd1;
        cmp_d   = wr_cmp   ? apply_be(cmp_q,   dwdata_i, dwe_i) : cmp_q;

        // Set wins over a same-cycle W1C
        pending_d = pending_q;
        if (wr_status && dwdata_i[ST_PENDING]) pending_d = 1'b0;
        if (match)                             pending_d = 1'b1;

        overflow_d = overflow_q;
        if (wr_status && dwdata_i[ST_OVERFLOW]) overflow_d = 1'b0;
        if (fifo_rej)                           overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q    <= '0;
            cmp_q      <= CMP_RESET;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            cmp_q      <= cmp_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        status                             = '0;
        status[ST_PENDING]                 = pending_q;
        status[ST_FULL]                    = fifo_full;
        status[ST_EMPTY]                   = fifo_empty;
        status[ST_OVERFLOW]                = overflow_q;
        status[ST_COUNT_MSB:ST_COUNT_LSB]  = 4'(fifo_count);
    end

    always_comb begin
        rdata_o = '0;
        if (hit_o) begin
            case (off)
                OFF_TIMER:  rdata_o = timer_q;
                OFF_CMP:    rdata_o = cmp_q;
                OFF_STATUS: rdata_o = status;
                default:    rdata_o = '0;
            endcase
        end
    end

endmodule
